// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline stall/flush controller with multicycle EX hold and event counters

module hazard_ctrl_unit #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mc_start,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CW = $clog2(MC_CYCLES + 1);
  // Remaining busy cycles after the start cycle; the start cycle itself is spent in IDLE.
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_CYCLES - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MC_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             load_use;
  logic             rs1_hit, rs2_hit;

  // A load in EX whose destination feeds a source read in ID; x0 never creates a dependency.
  assign rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
  assign load_use = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  // State register and multicycle occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a taken branch in IDLE suppresses the multicycle start; MC_BUSY ignores all inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!ex_branch_taken && ex_mc_start && (MC_CYCLES > 1)) begin
          state_d = S_MC_BUSY;
          cnt_d   = MC_LOAD;
        end
      end
      S_MC_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: flush wins over stall; both forced low while reset is held.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (ex_branch_taken) begin
            flush = 1'b1;
          end else if (ex_mc_start) begin
            stall = 1'b1;
          end else begin
            stall = load_use;
          end
        end
        S_MC_BUSY: begin
          stall = 1'b1;
        end
        default: begin
          stall = 1'b0;
          flush = 1'b0;
        end
      endcase
    end
  end

  assign pc_write_en    = ~stall;
  assign if_id_write_en = ~stall;
  assign mc_busy        = (state_q == S_MC_BUSY);

  // Saturating event counters: next value.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (flush && (flush_count_q != {CNT_W{1'b1}})) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // Saturating event counters: registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
